// File: rtl/cond_pipe_ctrl.sv
// Purpose: carries decoder controls D->E->M->W, evaluates ARM condition codes in E against the owned NZCV register, squashes failed instructions.
// Latency: D->E 1 cycle, D->M 2 cycles, D->W 3 cycles; condition result and branch-taken are combinational in E.
// Backpressure: none; stages advance every cycle, FlushE injects a bubble. Optional perf counters under COND_PIPE_PERF_EN.
module cond_pipe_ctrl #(
    parameter int         WA_W      = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            PCSrcD,
    input  logic            RegWriteD,
    input  logic            MemtoRegD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ALUControlD,
    input  logic [1:0]      FlagWriteD,
    input  logic [3:0]      CondD,
    input  logic [WA_W-1:0] WA3D,
    input  logic            FlushE,
    input  logic [3:0]      ALUFlagsE,
    output logic [1:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            BranchTakenE,
    output logic            CondExE,
    output logic            RegWriteM,
    output logic            MemtoRegM,
    output logic            MemWriteM,
    output logic            PCSrcM,
    output logic [WA_W-1:0] WA3M,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic            PCSrcW,
    output logic [WA_W-1:0] WA3W,
    output logic [3:0]      FlagsQ,
    output logic [15:0]     SquashCnt,
    output logic [15:0]     BubbleCnt
);

    // Execute-stage register contents
    logic            pcsrc_e;
    logic            regwrite_e;
    logic            memtoreg_e;
    logic            memwrite_e;
    logic            branch_e;
    logic            alusrc_e;
    logic [1:0]      alucontrol_e;
    logic [1:0]      flagwrite_e;
    logic [3:0]      cond_e;
    logic [WA_W-1:0] wa3_e;

    // NZCV register
    logic flag_n, flag_z, flag_c, flag_v;

    logic cond_ex;

    // D->E register: capture decode controls, or a bubble (all zero, condition AL) on flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcsrc_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memtoreg_e   <= 1'b0;
            memwrite_e   <= 1'b0;
            branch_e     <= 1'b0;
            alusrc_e     <= 1'b0;
            alucontrol_e <= 2'b00;
            flagwrite_e  <= 2'b00;
            cond_e       <= 4'b0000;
            wa3_e        <= '0;
        end else if (FlushE) begin
            pcsrc_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memtoreg_e   <= 1'b0;
            memwrite_e   <= 1'b0;
            branch_e     <= 1'b0;
            alusrc_e     <= 1'b0;
            alucontrol_e <= 2'b00;
            flagwrite_e  <= 2'b00;
            cond_e       <= 4'b1110;
            wa3_e        <= '0;
        end else begin
            pcsrc_e      <= PCSrcD;
            regwrite_e   <= RegWriteD;
            memtoreg_e   <= MemtoRegD;
            memwrite_e   <= MemWriteD;
            branch_e     <= BranchD;
            alusrc_e     <= ALUSrcD;
            alucontrol_e <= ALUControlD;
            flagwrite_e  <= FlagWriteD;
            cond_e       <= CondD;
            wa3_e        <= WA3D;
        end
    end

    // Condition evaluation against the committed flags (no bypass of the current E write)
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = branch_e & cond_ex;
    assign ALUControlE  = alucontrol_e;
    assign ALUSrcE      = alusrc_e;
    assign FlagsQ       = {flag_n, flag_z, flag_c, flag_v};

    // Flags update: NZ and CV halves written independently, only by passing instructions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {flag_n, flag_z, flag_c, flag_v} <= FLAGS_RST;
        end else begin
            if (flagwrite_e[1] & cond_ex) begin
                {flag_n, flag_z} <= ALUFlagsE[3:2];
            end
            if (flagwrite_e[0] & cond_ex) begin
                {flag_c, flag_v} <= ALUFlagsE[1:0];
            end
        end
    end

    // E->M register: state-changing controls are gated by the condition result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            MemWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
            WA3M      <= '0;
        end else begin
            RegWriteM <= regwrite_e & cond_ex;
            MemtoRegM <= memtoreg_e;
            MemWriteM <= memwrite_e & cond_ex;
            PCSrcM    <= pcsrc_e & cond_ex;
            WA3M      <= wa3_e;
        end
    end

    // M->W register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            WA3W      <= '0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            PCSrcW    <= PCSrcM;
            WA3W      <= WA3M;
        end
    end

`ifdef COND_PIPE_PERF_EN
    logic [15:0] squash_cnt;
    logic [15:0] bubble_cnt;
    logic        has_effect_e;

    assign has_effect_e = regwrite_e | memwrite_e | pcsrc_e | branch_e | (|flagwrite_e);

    // Saturating counters: squashed effectful instructions and injected bubbles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            squash_cnt <= 16'h0000;
            bubble_cnt <= 16'h0000;
        end else begin
            if (has_effect_e & ~cond_ex & (squash_cnt != 16'hFFFF)) begin
                squash_cnt <= squash_cnt + 16'd1;
            end
            if (FlushE & (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

    assign SquashCnt = squash_cnt;
    assign BubbleCnt = bubble_cnt;
`else
    assign SquashCnt = 16'h0000;
    assign BubbleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_pipe_ctrl.sv
// Testbench for cond_pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Perf counter expectations follow COND_PIPE_PERF_EN (zero when undefined).
module tb_cond_pipe_ctrl;
    localparam int WA_W = 4;
`ifdef COND_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic            pcsrc;
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
        logic            branch;
        logic            alusrc;
        logic [1:0]      aluctl;
        logic [1:0]      flagwr;
        logic [3:0]      cond;
        logic [WA_W-1:0] wa;
    } dbun_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu = 4'b0000;
    dbun_t       din = '0;

    logic [1:0]      ALUControlE;
    logic            ALUSrcE, BranchTakenE, CondExE;
    logic            RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
    logic [WA_W-1:0] WA3M;
    logic            RegWriteW, MemtoRegW, PCSrcW;
    logic [WA_W-1:0] WA3W;
    logic [3:0]      FlagsQ;
    logic [15:0]     SquashCnt, BubbleCnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cond_pipe_ctrl #(.WA_W(WA_W), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .PCSrcD(din.pcsrc), .RegWriteD(din.regwrite), .MemtoRegD(din.memtoreg),
        .MemWriteD(din.memwrite), .BranchD(din.branch), .ALUSrcD(din.alusrc),
        .ALUControlD(din.aluctl), .FlagWriteD(din.flagwr), .CondD(din.cond), .WA3D(din.wa),
        .FlushE(flush), .ALUFlagsE(alu),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BranchTakenE(BranchTakenE), .CondExE(CondExE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .WA3M(WA3M),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
        .FlagsQ(FlagsQ), .SquashCnt(SquashCnt), .BubbleCnt(BubbleCnt)
    );

    wire [19:0] outs = {ALUControlE, ALUSrcE, BranchTakenE, CondExE,
                        RegWriteM, MemtoRegM, MemWriteM, PCSrcM, WA3M,
                        RegWriteW, MemtoRegW, PCSrcW, WA3W};

    // ARM conditions come in complementary pairs: odd codes invert the even base
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Put a flag-setting AL instruction through E so FlagsQ becomes f
    task automatic set_flags(input logic [3:0] f);
        din = '0; din.cond = 4'hE; din.flagwr = 2'b11;
        tick();
        alu = f; din = '0;
        tick();
        alu = 4'b0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; din = '0; flush = 1'b0; alu = 4'b0000;
        repeat (3) tick();
        total++; if (outs !== 20'h0) $display("FAIL reset_outs got=%h exp=0", outs); else passed++;
        total++; if (FlagsQ !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", FlagsQ); else passed++;
        total++; if ({SquashCnt, BubbleCnt} !== 32'h0) $display("FAIL reset_cnt got=%h exp=0", {SquashCnt, BubbleCnt}); else passed++;
        reset_n = 1'b1;
        tick();
        total++; if (outs !== 20'h0) $display("FAIL release_outs got=%h exp=0", outs); else passed++;
    endtask

    task automatic test_flag_eq();
        din = '0; din.cond = 4'hE; din.flagwr = 2'b11;
        tick();
        alu = 4'b0100; din = '0; din.cond = 4'h0; din.regwrite = 1'b1; din.wa = 4'd5;
        tick();
        total++; if (FlagsQ !== 4'b0100) $display("FAIL eq_flags got=%b exp=0100", FlagsQ); else passed++;
        total++; if (CondExE !== 1'b1) $display("FAIL eq_condex got=%b exp=1", CondExE); else passed++;
        alu = 4'b0000; din = '0;
        tick();
        total++; if ({RegWriteM, WA3M} !== {1'b1, 4'd5}) $display("FAIL eq_mem got=%b exp=10101", {RegWriteM, WA3M}); else passed++;
        tick();
        total++; if ({RegWriteW, WA3W} !== {1'b1, 4'd5}) $display("FAIL eq_wb got=%b exp=10101", {RegWriteW, WA3W}); else passed++;
    endtask

    task automatic test_failed_cond();
        din = '0; din.cond = 4'h1; din.regwrite = 1'b1; din.memwrite = 1'b1; din.branch = 1'b1; din.flagwr = 2'b11;
        tick();
        alu = 4'b1111; din = '0;
        total++; if ({CondExE, BranchTakenE} !== 2'b00) $display("FAIL ne_exec got=%b exp=00", {CondExE, BranchTakenE}); else passed++;
        tick();
        alu = 4'b0000;
        total++; if ({RegWriteM, MemWriteM} !== 2'b00) $display("FAIL ne_mem got=%b exp=00", {RegWriteM, MemWriteM}); else passed++;
        total++; if (FlagsQ !== 4'b0100) $display("FAIL ne_flags got=%b exp=0100", FlagsQ); else passed++;
    endtask

    task automatic test_flush();
        din = '0; din.regwrite = 1'b1; din.branch = 1'b1; din.aluctl = 2'b11; din.cond = 4'hE; flush = 1'b1;
        tick();
        flush = 1'b0; din = '0;
        total++; if ({ALUControlE, BranchTakenE, CondExE} !== 4'b0001) $display("FAIL flush_exec got=%b exp=0001", {ALUControlE, BranchTakenE, CondExE}); else passed++;
        tick();
        total++; if (RegWriteM !== 1'b0) $display("FAIL flush_mem got=%b exp=0", RegWriteM); else passed++;
    endtask

    task automatic test_signed();
        set_flags(4'b1000); din.cond = 4'hB;
        tick();
        total++; if (CondExE !== 1'b1) $display("FAIL lt_nv10 got=%b exp=1", CondExE); else passed++;
        set_flags(4'b1001); din.cond = 4'hC;
        tick();
        total++; if (CondExE !== 1'b1) $display("FAIL gt_z0 got=%b exp=1", CondExE); else passed++;
        set_flags(4'b1101); din.cond = 4'hC;
        tick();
        total++; if (CondExE !== 1'b0) $display("FAIL gt_z1 got=%b exp=0", CondExE); else passed++;
        din = '0;
    endtask

    task automatic test_perf_async_reset();
        reset_n = 1'b0; din = '0; flush = 1'b0; alu = 4'b0000;
        tick();
        reset_n = 1'b1; flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0; din.cond = 4'h0; din.regwrite = 1'b1;
        tick();
        tick();
        din = '0;
        tick();
        total++; if (BubbleCnt !== (PERF ? 16'd3 : 16'd0)) $display("FAIL perf_bubble got=%0d exp=%0d", BubbleCnt, PERF ? 3 : 0); else passed++;
        total++; if (SquashCnt !== (PERF ? 16'd2 : 16'd0)) $display("FAIL perf_squash got=%0d exp=%0d", SquashCnt, PERF ? 2 : 0); else passed++;
        set_flags(4'b1010);
        total++; if (FlagsQ !== 4'b1010) $display("FAIL pre_areset_flags got=%b exp=1010", FlagsQ); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if (FlagsQ !== 4'b0000) $display("FAIL areset_flags got=%b exp=0000", FlagsQ); else passed++;
        total++; if ({SquashCnt, BubbleCnt} !== 32'h0) $display("FAIL areset_cnt got=%h exp=0", {SquashCnt, BubbleCnt}); else passed++;
        total++; if (outs !== 20'h0) $display("FAIL areset_outs got=%h exp=0", outs); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        dbun_t          e;
        logic [7:0]     m_exp;
        logic [6:0]     w_exp;
        logic [3:0]     mf;
        int unsigned    sq, bb;
        bit             ce, eff;
        logic [31:0]    r;
        reset_n = 1'b0; din = '0; flush = 1'b0; alu = 4'b0000;
        tick();
        reset_n = 1'b1;
        e = '0; m_exp = '0; w_exp = '0; mf = 4'b0000; sq = 0; bb = 0;
        for (int i = 0; i < 400; i++) begin
            ce = cond_ok(e.cond, mf);
            total++; if ({ALUControlE, ALUSrcE, CondExE, BranchTakenE} !== {e.aluctl, e.alusrc, ce, e.branch & ce})
                $display("FAIL rnd_exec i=%0d got=%b exp=%b", i, {ALUControlE, ALUSrcE, CondExE, BranchTakenE}, {e.aluctl, e.alusrc, ce, e.branch & ce}); else passed++;
            total++; if ({RegWriteM, MemtoRegM, MemWriteM, PCSrcM, WA3M} !== m_exp)
                $display("FAIL rnd_mem i=%0d got=%b exp=%b", i, {RegWriteM, MemtoRegM, MemWriteM, PCSrcM, WA3M}, m_exp); else passed++;
            total++; if ({RegWriteW, MemtoRegW, PCSrcW, WA3W} !== w_exp)
                $display("FAIL rnd_wb i=%0d got=%b exp=%b", i, {RegWriteW, MemtoRegW, PCSrcW, WA3W}, w_exp); else passed++;
            total++; if (FlagsQ !== mf) $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, FlagsQ, mf); else passed++;
            total++; if ({SquashCnt, BubbleCnt} !== (PERF ? {sq[15:0], bb[15:0]} : 32'h0))
                $display("FAIL rnd_cnt i=%0d got=%h exp=%h", i, {SquashCnt, BubbleCnt}, PERF ? {sq[15:0], bb[15:0]} : 32'h0); else passed++;
            r = $urandom;
            din = r[$bits(dbun_t)-1:0];
            flush = ($urandom_range(0, 3) == 0);
            alu = 4'($urandom_range(0, 15));
            eff = e.regwrite || e.memwrite || e.pcsrc || e.branch || (e.flagwr != 2'b00);
            if (eff && !ce && sq < 32'hFFFF) sq++;
            if (flush && bb < 32'hFFFF) bb++;
            w_exp = {m_exp[7], m_exp[6], m_exp[4], m_exp[3:0]};
            m_exp = {e.regwrite & ce, e.memtoreg, e.memwrite & ce, e.pcsrc & ce, e.wa};
            if (e.flagwr[1] && ce) mf[3:2] = alu[3:2];
            if (e.flagwr[0] && ce) mf[1:0] = alu[1:0];
            if (flush) begin
                e = '0; e.cond = 4'hE;
            end else begin
                e = din;
            end
            tick();
        end
        flush = 1'b0; din = '0;
    endtask

    initial begin
        test_reset();
        test_flag_eq();
        test_failed_cond();
        test_flush();
        test_signed();
        test_perf_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cond_pipe_ctrl.md
Name: cond_pipe_ctrl

Overview:
- Downstream companion of the decoder/control unit in the pipelined ARM core.
- Takes the Decode-stage control bundle and carries it through the Execute, Memory and Writeback pipeline registers.
- Evaluates the instruction condition field in Execute against the architectural NZCV flags register, which this block owns.
- Squashes state-changing controls of failed instructions and produces the branch-taken and writeback controls used by the datapath and hazard unit.

Parameters:
- WA_W, 4, width of destination register address.
- FLAGS_RST, 4'b0000, reset value of the NZCV register, ordered {N,Z,C,V}.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoder controls, Decode stage.
- ALUControlD  in  2  ALU operation select.
- FlagWriteD  in  2  bit1 = NZ write enable, bit0 = CV write enable.
- CondD  in  4  Instr[31:28].
- WA3D  in  WA_W  destination register.
- FlushE  in  1  inject bubble into the D->E register.
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU in Execute.
- ALUControlE  out  2  Execute ALU operation.
- ALUSrcE  out  1  Execute ALU operand select.
- BranchTakenE  out  1  BranchE & CondExE.
- CondExE  out  1  condition passed in Execute.
- RegWriteM, MemtoRegM, MemWriteM, PCSrcM  out  1 each  Memory-stage controls.
- WA3M  out  WA_W  Memory-stage destination register.
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  Writeback-stage controls.
- WA3W  out  WA_W  Writeback-stage destination register.
- FlagsQ  out  4  current NZCV register.
- SquashCnt, BubbleCnt  out  16 each  performance counters; see Optional Feature.

Behaviour:
- Reset (async, reset_n=0):
  - All pipeline registers clear to 0, which gives every output 0.
  - FlagsQ = FLAGS_RST.
  - Counters = 0.
  - Release is synchronous to the next clk edge.
- D->E register:
  - Captures all D inputs each cycle.
  - If FlushE=1, captures all-zero controls instead. This is a bubble, and CondE=4'b1110.
- Condition evaluation (combinational, Execute stage):
  - CondExE is computed from CondE and FlagsQ per the ARM table:
    - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
    - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
    - GT !Z&(N==V); LE Z|(N!=V).
    - AL 1; 1111 evaluates as 1.
- Gating in Execute:
  - Gated controls are RegWrite = RegWriteE&CondExE, MemWrite = MemWriteE&CondExE, and PCSrc = PCSrcE&CondExE.
  - BranchTakenE = BranchE&CondExE.
- Flags register:
  - On clk, if FlagWriteE[1]&CondExE then {N,Z} <= ALUFlagsE[3:2].
  - On clk, if FlagWriteE[0]&CondExE then {C,V} <= ALUFlagsE[1:0].
  - An instruction in Execute sees the flags written by its predecessor. No same-cycle bypass.
- E->M register: captures the gated controls plus MemtoRegE and WA3E. Latency D->M is 2 cycles.
- M->W register: captures RegWriteM, MemtoRegM, PCSrcM and WA3M. Latency D->W is 3 cycles.
- No stall inputs: the E, M and W registers advance every cycle.
- Flush and flag write in the same cycle: the instruction currently in E still writes flags. The flush affects only the incoming capture.
- Reset mid-operation: in-flight instructions are discarded and flags return to FLAGS_RST.

Optional Feature:
- Macro COND_PIPE_PERF_EN.
- When defined:
  - SquashCnt increments each cycle an instruction in E with any of RegWriteE, MemWriteE, PCSrcE, BranchE or FlagWriteE nonzero has CondExE=0.
  - BubbleCnt increments each cycle FlushE=1.
  - Both counters saturate at 16'hFFFF.
  - Both counters clear on reset.
- When undefined: both ports are tied to 16'h0000 and no counter flops are built.

Test Plan:
1. Reset check:
   - Stimulus: reset_n low for 3 cycles.
   - Response: all outputs 0 and FlagsQ=0000; release leaves all outputs 0.
2. Flag set and EQ condition:
   - Stimulus: SUBS-like op (FlagWriteD=11, CondD=1110, ALUFlagsE=0100).
   - Response: FlagsQ=0100 one cycle after E.
   - Follow-on: a following CondD=0000 RegWriteD=1 with WA3D=5 gives RegWriteW=1 and WA3W=5 three cycles after D.
3. Failed condition:
   - Stimulus: FlagsQ=0100, then CondD=0001 with RegWriteD=1, MemWriteD=1, BranchD=1.
   - Response: CondExE=0, BranchTakenE=0, RegWriteM=0, MemWriteM=0; FlagsQ unchanged.
4. Flush:
   - Stimulus: FlushE=1 while D holds RegWriteD=1, BranchD=1.
   - Response: next cycle ALUControlE=00, BranchTakenE=0, CondExE=1; RegWriteM=0 the cycle after.
5. Signed compares:
   - Stimulus: flags {N,V}=10 with CondD=1011 (LT).
   - Response: CondExE=1.
   - Follow-on: flags {N,V}=11 with CondD=1100 (GT) and Z=0 gives CondExE=1; Z=1 gives CondExE=0.
6. Perf counters and async reset (COND_PIPE_PERF_EN defined):
   - Stimulus: 3 flushes and 2 squashed instructions.
   - Response: BubbleCnt=3, SquashCnt=2.
   - Follow-on: asserting reset_n=0 between clk edges clears them immediately.
